cross_unit_arbiter: RTL and testbench

- Shares one pipelined signed cross-product unit (Ax*By - Ay*Bx) among NREQ requesters.
- Requesters are the geofence point-sort and edge-side test engines.
- Arbitration is round-robin, accepting at most one operation per cycle.
- Each result comes back NREQ-tagged with its originating requester ID and a "strictly positive" flag, so engines no longer instantiate private multipliers.

---
 rtl/cross_unit_arbiter.sv | 115 +++++++++++
 tb/tb_cross_unit_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cross_unit_arbiter.sv
// Round-robin arbiter sharing one two-stage signed cross-product unit.
// Results return tagged with the requester ID and a strictly-positive flag.
module cross_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2,
    parameter int W    = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   op_ax,
    input  logic [NREQ*W-1:0]   op_ay,
    input  logic [NREQ*W-1:0]   op_bx,
    input  logic [NREQ*W-1:0]   op_by,
    output logic [NREQ-1:0]     gnt,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [2*W:0]        rsp_val,
    output logic                rsp_pos
);

    logic [ID_W-1:0]          ptr;
    logic [ID_W-1:0]          ptr_next;
    logic [ID_W-1:0]          winner;
    logic                     any;
    int                       idx;

    logic signed [W-1:0]      ax, ay, bx, by;
    logic signed [2*W-1:0]    m1, m2;

    logic                     s1_valid;
    logic [ID_W-1:0]          s1_id;
    logic signed [2*W-1:0]    p1, p2;
    logic signed [2*W:0]      diff;

    // Rotating-priority search from ptr; no grant while reset is held.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!any && req[idx]) begin
                    any    = 1'b1;
                    winner = idx[ID_W-1:0];
                end
            end
            if (any) gnt[winner] = 1'b1;
        end
    end

    // Next priority pointer with explicit wrap for non power-of-two NREQ.
    always_comb begin
        ptr_next = ptr;
        if (any) begin
            if (winner == ID_W'(NREQ - 1)) ptr_next = '0;
            else                           ptr_next = winner + 1'b1;
        end
    end

    // Select the winner's operands and form both partial products.
    always_comb begin
        ax = op_ax[int'(winner)*W +: W];
        ay = op_ay[int'(winner)*W +: W];
        bx = op_bx[int'(winner)*W +: W];
        by = op_by[int'(winner)*W +: W];
        m1 = (2*W)'(ax) * (2*W)'(by);
        m2 = (2*W)'(ay) * (2*W)'(bx);
    end

    // Difference is one bit wider than the products, so it cannot overflow.
    always_comb begin
        diff = (2*W+1)'(p1) - (2*W+1)'(p2);
    end

    // Stage 1: accept the granted operation and advance the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            p1       <= '0;
            p2       <= '0;
        end else begin
            ptr      <= ptr_next;
            s1_valid <= any;
            if (any) begin
                s1_id <= winner;
                p1    <= m1;
                p2    <= m2;
            end
        end
    end

    // Stage 2: retire the result; data holds when no operation arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_val   <= '0;
            rsp_pos   <= 1'b0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id  <= s1_id;
                rsp_val <= diff;
                rsp_pos <= (p1 > p2);
            end
        end
    end

endmodule

// File: tb/tb_cross_unit_arbiter.sv
// Directed self-checking bench for cross_unit_arbiter.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_cross_unit_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int W    = 11;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   op_ax, op_ay, op_bx, op_by;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [2*W:0]        rsp_val;
    logic                rsp_pos;

    int n_assert = 0;
    int n_fail   = 0;

    cross_unit_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_ax     (op_ax),
        .op_ay     (op_ay),
        .op_bx     (op_bx),
        .op_by     (op_by),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_val   (rsp_val),
        .rsp_pos   (rsp_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sval();
        return int'($signed(rsp_val));
    endfunction

    task automatic set_op(input int i, input int ax, input int ay,
                          input int bx, input int by);
        op_ax[i*W +: W] = W'(ax);
        op_ay[i*W +: W] = W'(ay);
        op_bx[i*W +: W] = W'(bx);
        op_by[i*W +: W] = W'(by);
    endtask

    // Starts just after a falling edge; ends 1ns after the accept edge.
    task automatic issue(input string tag, input int i, input int exp_gnt);
        req = NREQ'(1) << i;
        #1;
        chk({tag, "_gnt"}, int'(gnt), exp_gnt);
        @(posedge clk);
        #1;
        req = '0;
    endtask

    // Follows issue(): result must be a single pulse two clocks after grant.
    task automatic expect_rsp(input string tag, input int id,
                              input int val, input int pos);
        @(negedge clk);
        chk({tag, "_early"}, int'(rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(rsp_valid), 1);
        chk({tag, "_id"}, int'(rsp_id), id);
        chk({tag, "_val"}, sval(), val);
        chk({tag, "_pos"}, int'(rsp_pos), pos);
        @(negedge clk);
        chk({tag, "_drop"}, int'(rsp_valid), 0);
        chk({tag, "_hold"}, sval(), val);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '1;
        op_ax = '0;
        op_ay = '0;
        op_bx = '0;
        op_by = '0;
        #2;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_val", sval(), 0);
        chk("rst_pos", int'(rsp_pos), 0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single op
        set_op(0, 3, 0, 0, 4);
        issue("single", 0, 4'b0001);
        expect_rsp("single", 0, 12, 1);

        // Sign and zero on requester 2
        set_op(2, 2, 5, 4, 10);
        issue("zero", 2, 4'b0100);
        expect_rsp("zero", 2, 0, 0);
        set_op(2, 1, 2, 3, 1);
        issue("neg", 2, 4'b0100);
        expect_rsp("neg", 2, -5, 0);

        // Round-robin under full contention
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 0, 0, 2);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_gnt%0d", c), int'(gnt), 1 << (c % 4));
            if (c >= 2) begin
                chk($sformatf("rr_v%0d", c), int'(rsp_valid), 1);
                chk($sformatf("rr_id%0d", c), int'(rsp_id), (c - 2) % 4);
                chk($sformatf("rr_val%0d", c), sval(), 2 * ((c - 2) % 4 + 1));
            end else begin
                chk($sformatf("rr_v%0d", c), int'(rsp_valid), 0);
            end
            @(posedge clk);
            #1;
            if (c == 7) req = '0;
            @(negedge clk);
        end
        for (int c = 8; c < 10; c++) begin
            chk($sformatf("rr_v%0d", c), int'(rsp_valid), 1);
            chk($sformatf("rr_id%0d", c), int'(rsp_id), (c - 2) % 4);
            @(negedge clk);
        end
        chk("rr_end", int'(rsp_valid), 0);

        // Pointer skip: after grant to 1, ptr=2, so req=0011 wraps to 0
        set_op(1, 1, 0, 0, 1);
        issue("skip_g1", 1, 4'b0010);
        req = 4'b0011;
        #1;
        chk("skip_wrap", int'(gnt), 4'b0001);
        @(posedge clk);
        #1;
        req = 4'b0010;
        #1;
        chk("skip_next", int'(gnt), 4'b0010);
        @(posedge clk);
        #1;
        req = '0;
        repeat (4) @(negedge clk);
        chk("skip_idle", int'(rsp_valid), 0);

        // Extreme operand values on requester 3
        set_op(3, -1024, -1024, 1023, -1024);
        issue("ext_pos", 3, 4'b1000);
        expect_rsp("ext_pos", 3, 2096128, 1);
        set_op(3, 1023, -1024, -1024, -1024);
        issue("ext_neg", 3, 4'b1000);
        expect_rsp("ext_neg", 3, -2096128, 0);

        // Reset mid-flight discards the op and returns ptr to 0
        set_op(2, 5, 0, 0, 5);
        issue("mid", 2, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_v", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        chk("mid_ptr", int'(gnt), 4'b0001);
        @(negedge clk);
        chk("mid_lost", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        req = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
